// File: rtl/yc_cvbs_mix.sv
// Y/C to composite mixer: three-stage scale/sum/clip pipeline with a sync-tip and
// back-porch FSM, S-Video bypass, and a per-field line counter.
module yc_cvbs_mix #(
  parameter logic [7:0] SYNC_LEVEL  = 8'd0,
  parameter logic [7:0] BLANK_LEVEL = 8'd64,
  parameter logic [8:0] Y_GAIN      = 9'd192,
  parameter logic [8:0] C_GAIN      = 9'd256,
  parameter logic [8:0] BP_LEN      = 9'd260
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        CVBS_EN,
  input  logic [23:0] din,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        csync,
  output logic [23:0] dout,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        csync_o,
  output logic [9:0]  line_cnt,
  output logic        odd_line
);

  typedef enum logic [1:0] {S_WAIT, S_SYNC, S_PORCH, S_ACTIVE} state_t;

  // syncs are carried as {hsync, vsync, csync}
  logic [16:0]        y_m_q, y_m_d;
  logic signed [17:0] c_m_q, c_m_d;
  logic signed [9:0]  c_off;
  logic [23:0]        din1_q, din2_q, dout_q, dout_d;
  logic [2:0]         sync1_q, sync2_q, sync3_q;
  logic [10:0]        sum_q, sum_d;
  logic signed [9:0]  cs_q, cs_d;
  logic [10:0]        porch_sum;
  state_t             state_q, state_d;
  logic [8:0]         pcnt_q, pcnt_d;
  logic               mode_q, mode_d;
  logic [9:0]         lcnt_q, lcnt_d;
  logic               c_rise, v_rise;
  logic [7:0]         cvbs;

  function automatic logic [7:0] clip8(input logic [10:0] v);
    if (v[10])           return 8'd0;
    else if (v[9:8] != 2'b00) return 8'd255;
    else                 return v[7:0];
  endfunction

  assign c_off = $signed({2'b00, din[23:16]}) - 10'sd128;
  assign y_m_d = din[15:8] * Y_GAIN;
  assign c_m_d = c_off * $signed({1'b0, C_GAIN});

  assign cs_d  = 10'(c_m_q >>> 8);
  assign sum_d = {3'b000, BLANK_LEVEL} + {3'b000, 8'(y_m_q >> 8)} + {cs_d[9], cs_d};

  assign porch_sum = {3'b000, BLANK_LEVEL} + {cs_q[9], cs_q};

  // sync3_q doubles as the previous value of the stage-2 syncs for edge detect
  assign c_rise = sync2_q[0] & ~sync3_q[0];
  assign v_rise = sync2_q[1] & ~sync3_q[1];

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_WAIT: begin
        mode_d = CVBS_EN;
        if (c_rise) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!sync2_q[0]) begin
          state_d = S_PORCH;
          pcnt_d  = 9'd0;
        end
      end
      S_PORCH: begin
        if (c_rise)                          state_d = S_SYNC;
        else if (pcnt_q == 9'(BP_LEN - 9'd1)) state_d = S_ACTIVE;
        else                                 pcnt_d  = pcnt_q + 9'd1;
      end
      S_ACTIVE: begin
        if (c_rise) state_d = S_SYNC;
      end
      default: state_d = S_WAIT;
    endcase
    if (c_rise) mode_d = CVBS_EN;
  end

  // output selection follows the next state so it lines up with the S3 sample
  always_comb begin
    cvbs = BLANK_LEVEL;
    case (state_d)
      S_SYNC:   cvbs = SYNC_LEVEL;
      S_PORCH:  cvbs = clip8(porch_sum);
      S_ACTIVE: cvbs = clip8(sum_q);
      default:  cvbs = BLANK_LEVEL;
    endcase
    dout_d = mode_d ? {8'd128, cvbs, 8'd0} : din2_q;
  end

  always_comb begin
    lcnt_d = lcnt_q;
    if (v_rise)                          lcnt_d = 10'd0;
    else if (c_rise && lcnt_q != 10'd1023) lcnt_d = lcnt_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_m_q   <= '0;
      c_m_q   <= '0;
      din1_q  <= '0;
      din2_q  <= '0;
      dout_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      sum_q   <= '0;
      cs_q    <= '0;
      state_q <= S_WAIT;
      pcnt_q  <= '0;
      mode_q  <= 1'b0;
      lcnt_q  <= '0;
    end else if (ce) begin
      y_m_q   <= y_m_d;
      c_m_q   <= c_m_d;
      din1_q  <= din;
      sync1_q <= {hsync, vsync, csync};
      sum_q   <= sum_d;
      cs_q    <= cs_d;
      din2_q  <= din1_q;
      sync2_q <= sync1_q;
      dout_q  <= dout_d;
      sync3_q <= sync2_q;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      mode_q  <= mode_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign dout     = dout_q;
  assign hsync_o  = sync3_q[2];
  assign vsync_o  = sync3_q[1];
  assign csync_o  = sync3_q[0];
  assign line_cnt = lcnt_q;
  assign odd_line = lcnt_q[0];

endmodule

// File: tb/tb_yc_cvbs_mix.sv
// Directed scoreboard bench for yc_cvbs_mix: expected samples are queued as stimulus
// is driven and retired three ce cycles later when they reach dout.
module tb_yc_cvbs_mix;

  logic        clk = 1'b0;
  logic        reset_n, ce, CVBS_EN;
  logic [23:0] din;
  logic        hsync, vsync, csync;
  logic [23:0] dout;
  logic        hsync_o, vsync_o, csync_o;
  logic [9:0]  line_cnt;
  logic        odd_line;

  yc_cvbs_mix dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .CVBS_EN(CVBS_EN), .din(din),
    .hsync(hsync), .vsync(vsync), .csync(csync), .dout(dout),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .csync_o(csync_o),
    .line_cnt(line_cnt), .odd_line(odd_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [23:0] d;
    logic [2:0]  s;
  } exp_t;

  exp_t        q[$];
  int          errs = 0;
  int          checks = 0;
  logic [23:0] last_d = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] cv(input logic [7:0] v);
    return {8'd128, v, 8'd0};
  endfunction

  // one ce cycle: drive, queue the expectation, retire the sample now at dout
  task automatic step(input logic [7:0] y, input logic [7:0] c, input logic cs,
                      input logic v, input bit chk, input logic [23:0] expd);
    exp_t e;
    din   = {c, y, 8'd0};
    csync = cs;
    hsync = cs;
    vsync = v;
    q.push_back('{chk, expd, {cs, v, cs}});
    @(posedge clk); #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      if (e.chk) begin
        check("dout", {8'd0, dout}, {8'd0, e.d});
        last_d = e.d;
      end
      check("syncs", {29'd0, hsync_o, vsync_o, csync_o}, {29'd0, e.s});
    end
  endtask

  task automatic reset_phase(input int n);
    reset_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      din = 24'hA5C3_00 ^ 24'(i); csync = i[0]; hsync = 1'b1; vsync = ~i[0];
      @(posedge clk); #1;
      check("rst_dout", {8'd0, dout}, 32'd0);
      check("rst_syncs", {29'd0, hsync_o, vsync_o, csync_o}, 32'd0);
      check("rst_line", {22'd0, line_cnt}, 32'd0);
      check("rst_odd", {31'd0, odd_line}, 32'd0);
    end
    q.delete();
    reset_n = 1'b1;
  endtask

  task automatic pulse(input int hi, input int lo, input logic v_hi, input logic v_lo);
    for (int i = 0; i < hi; i++) step(8'd50, 8'd90, 1'b1, v_hi, 1'b1, {8'd90, 8'd50, 8'd0});
    for (int i = 0; i < lo; i++) step(8'd50, 8'd90, 1'b0, v_lo, 1'b1, {8'd90, 8'd50, 8'd0});
  endtask

  initial begin
    ce = 1'b1; CVBS_EN = 1'b1; din = '0; hsync = 0; vsync = 0; csync = 0;

    // reset with live inputs, then WAIT outputs blank in composite mode
    reset_phase(4);
    for (int i = 0; i < 5; i++) step(8'd0, 8'd128, 1'b0, 1'b0, 1'b1, cv(8'd64));

    // sync tip, back porch (chroma only), then active line
    for (int i = 0; i < 5; i++) step(8'd200, 8'd160, 1'b1, 1'b0, 1'b1, cv(8'd0));
    for (int i = 0; i < 260; i++) step(8'd200, 8'd160, 1'b0, 1'b0, 1'b1, cv(8'd96));
    for (int i = 0; i < 6; i++) step(8'd200, 8'd160, 1'b0, 1'b0, 1'b1, cv(8'd246));
    check("line_after_1", {22'd0, line_cnt}, 32'd1);
    check("odd_after_1", {31'd0, odd_line}, 32'd1);

    // active-line arithmetic and clipping
    step(8'd255, 8'd128, 1'b0, 1'b0, 1'b1, cv(8'd255));
    step(8'd0,   8'd128, 1'b0, 1'b0, 1'b1, cv(8'd64));
    step(8'd128, 8'd200, 1'b0, 1'b0, 1'b1, cv(8'd232));
    step(8'd255, 8'd255, 1'b0, 1'b0, 1'b1, cv(8'd255));
    step(8'd0,   8'd0,   1'b0, 1'b0, 1'b1, cv(8'd0));
    step(8'd100, 8'd64,  1'b0, 1'b0, 1'b1, cv(8'd75));

    // mode change mid-line waits for the next sync
    CVBS_EN = 1'b0;
    for (int i = 0; i < 4; i++) step(8'd10, 8'd128, 1'b0, 1'b0, 1'b1, cv(8'd71));
    for (int i = 0; i < 5; i++) step(8'd10, 8'd128, 1'b1, 1'b0, 1'b1, {8'd128, 8'd10, 8'd0});
    for (int i = 0; i < 5; i++) step(8'd50, 8'd90, 1'b0, 1'b0, 1'b1, {8'd90, 8'd50, 8'd0});
    check("line_after_2", {22'd0, line_cnt}, 32'd2);

    // line counter: count, vsync clear, simultaneous rise
    pulse(2, 4, 1'b0, 1'b0);
    check("line_after_3", {22'd0, line_cnt}, 32'd3);
    pulse(0, 4, 1'b0, 1'b1);
    check("line_vclear", {22'd0, line_cnt}, 32'd0);
    pulse(0, 3, 1'b0, 1'b0);
    pulse(2, 4, 1'b0, 1'b0);
    check("line_recount", {22'd0, line_cnt}, 32'd1);
    pulse(2, 4, 1'b1, 1'b1);
    check("line_both_rise", {22'd0, line_cnt}, 32'd0);
    check("odd_both_rise", {31'd0, odd_line}, 32'd0);
    pulse(2, 4, 1'b1, 1'b1);
    check("line_vhigh", {22'd0, line_cnt}, 32'd1);

    // clock enable low freezes everything
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din = 24'($urandom); csync = i[0]; hsync = ~i[0]; vsync = i[1];
      @(posedge clk); #1;
      check("ce_dout", {8'd0, dout}, {8'd0, last_d});
      check("ce_line", {22'd0, line_cnt}, 32'd1);
    end
    ce = 1'b1;
    pulse(0, 4, 1'b1, 1'b1);

    // saturation of the line counter
    for (int i = 0; i < 1030; i++) pulse(1, 1, 1'b1, 1'b1);
    pulse(0, 3, 1'b1, 1'b1);
    check("line_sat", {22'd0, line_cnt}, 32'd1023);
    check("odd_sat", {31'd0, odd_line}, 32'd1);

    // reset mid-line: restart sits in WAIT with luma ignored
    CVBS_EN = 1'b1;
    reset_phase(2);
    for (int i = 0; i < 5; i++) step(8'd255, 8'd128, 1'b0, 1'b0, 1'b1, cv(8'd64));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
